// File: rtl/i2c_tx_fifo_if.sv
// Byte-FIFO bus between the APB register file (master) and the TX FIFO (slave).
// Carries push/pop requests, popped data and the status/error flags.
// No storage; purely a signal bundle with direction modports.
interface i2c_tx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output full, rd_data, rd_valid, empty, level, overflow, underflow
    );

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  full, rd_data, rd_valid, empty, level, overflow, underflow
    );
endinterface

// File: rtl/i2c_tx_fifo.sv
// Byte FIFO decoupling APB write bursts from the SCL-paced I2C byte engine.
// Latency: push visible in level next edge; pop data registered, 1 clock after rd_en.
// Backpressure: full/empty gate push/pop; rejected requests set sticky overflow/underflow.
module i2c_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    i2c_tx_fifo_if.slave      bus
);

    localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic full, empty;
    logic push_ok, pop_ok;

    // Status comes straight from the registered level so it never lags a transfer.
    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);

    assign push_ok = bus.wr_en && !full  && !bus.flush;
    assign pop_ok  = bus.rd_en && !empty && !bus.flush;

    always_comb begin
        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wptr_q] = bus.wr_data;
        end
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.flush) begin
            // rd_data is deliberately left alone so software still sees the last byte.
            wptr_d      = '0;
            rptr_d      = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_d     = rptr_q + 1'b1;
                rd_data_d  = mem_q[rptr_q];
                rd_valid_d = 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level_d = level_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                level_d = level_q - 1'b1;
            end
            if (bus.wr_en && full) begin
                overflow_d = 1'b1;
            end
            if (bus.rd_en && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Storage is never reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.level     = level_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Self-checking bench for i2c_tx_fifo: queue model of contents plus a scoreboard of popped bytes.
module tb_i2c_tx_fifo;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    i2c_tx_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    i2c_tx_fifo #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model [$];
    logic [7:0] exp_rd [$];
    logic       exp_vld;
    logic [7:0] exp_data;
    logic       exp_ovf;
    logic       exp_unf;
    logic [7:0] got;

    // One clock of stimulus; the model predicts acceptance from pre-edge occupancy.
    task automatic cyc(input logic f, input logic w, input logic [7:0] d, input logic r);
        logic push_ok, pop_ok;
        bus.flush   = f;
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        push_ok = !f && w && (model.size() < 8);
        pop_ok  = !f && r && (model.size() > 0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        exp_vld = pop_ok;
        if (f) begin
            model.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            if (w && !push_ok) exp_ovf = 1'b1;
            if (r && !pop_ok)  exp_unf = 1'b1;
            if (pop_ok) begin
                exp_data = model.pop_front();
                exp_rd.push_back(exp_data);
            end
            if (push_ok) model.push_back(d);
        end
    endtask

    task automatic model_reset();
        model.delete();
        exp_rd.delete();
        exp_vld  = 1'b0;
        exp_data = 8'h00;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1'b0, 1'b1, 8'h3C, 1'b0);
        cyc(1'b0, 1'b1, 8'hC3, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        exp_rd.delete();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.level !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: level=%0d empty=%b full=%b, want 0/1/0", bus.level, bus.empty, bus.full);
        end
        n_checks++;
        if (bus.rd_data !== 8'h00 || bus.rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rd: rd_data=%h rd_valid=%b, want 00/0", bus.rd_data, bus.rd_valid);
        end
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ovf=%b unf=%b, want 0/0", bus.overflow, bus.underflow);
        end
        release_reset();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 8'h11 + 8'(i), 1'b0);
            n_checks++;
            if (bus.level !== 4'(model.size())) begin
                n_fail++;
                $display("FAIL fill_level[%0d]: got %0d want %0d", i, bus.level, model.size());
            end
        end
        n_checks++;
        if (bus.full !== 1'b1 || bus.level !== 4'd8) begin
            n_fail++;
            $display("FAIL fill_full: full=%b level=%0d, want 1/8", bus.full, bus.level);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            got = (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hXX;
            n_checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== got || got !== 8'h11 + 8'(i)) begin
                n_fail++;
                $display("FAIL drain[%0d]: vld=%b data=%h, want 1/%h", i, bus.rd_valid, bus.rd_data, 8'h11 + 8'(i));
            end
        end
        n_checks++;
        if (bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_empty: got %b want 1", bus.empty);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h18) begin
            n_fail++;
            $display("FAIL drain_hold: vld=%b data=%h, want 0/18", bus.rd_valid, bus.rd_data);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h21 + 8'(i), 1'b0);
        cyc(1'b0, 1'b1, 8'hAA, 1'b0);
        n_checks++;
        if (bus.overflow !== exp_ovf || exp_ovf !== 1'b1 || bus.level !== 4'd8) begin
            n_fail++;
            $display("FAIL ovf_set: ovf=%b level=%0d, want 1/8", bus.overflow, bus.level);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            got = (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hXX;
            n_checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== got || bus.rd_data === 8'hAA) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d]: vld=%b data=%h, want 1/%h", i, bus.rd_valid, bus.rd_data, got);
            end
        end
        n_checks++;
        if (bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b want 1", bus.overflow);
        end
    endtask

    task automatic test_underflow();
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        n_checks++;
        if (bus.underflow !== 1'b1 || bus.rd_valid !== 1'b0 || bus.rd_data !== exp_data) begin
            n_fail++;
            $display("FAIL unf_set: unf=%b vld=%b data=%h, want 1/0/%h", bus.underflow, bus.rd_valid, bus.rd_data, exp_data);
        end
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0 || bus.rd_data !== exp_data) begin
            n_fail++;
            $display("FAIL unf_flush: unf=%b ovf=%b data=%h, want 0/0/%h", bus.underflow, bus.overflow, bus.rd_data, exp_data);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h31 + 8'(i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 8'h40 + 8'(i), 1'b1);
            got = (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hXX;
            n_checks++;
            if (bus.level !== 4'd3 || bus.rd_valid !== 1'b1 || bus.rd_data !== got) begin
                n_fail++;
                $display("FAIL simul[%0d]: level=%0d vld=%b data=%h, want 3/1/%h", i, bus.level, bus.rd_valid, bus.rd_data, got);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            got = (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hXX;
            n_checks++;
            if (bus.rd_data !== got || got !== 8'h47 + 8'(i)) begin
                n_fail++;
                $display("FAIL simul_tail[%0d]: data=%h want %h", i, bus.rd_data, 8'h47 + 8'(i));
            end
        end
        cyc(1'b0, 1'b1, 8'h77, 1'b1);
        n_checks++;
        if (bus.level !== 4'd1 || bus.underflow !== 1'b1 || bus.rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_empty: level=%0d unf=%b vld=%b, want 1/1/0", bus.level, bus.underflow, bus.rd_valid);
        end
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h61 + 8'(i), 1'b0);
        cyc(1'b0, 1'b1, 8'hBB, 1'b1);
        got = (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hXX;
        n_checks++;
        if (bus.level !== 4'd7 || bus.overflow !== 1'b1 || bus.rd_data !== 8'h61 || got !== 8'h61) begin
            n_fail++;
            $display("FAIL simul_full: level=%0d ovf=%b data=%h, want 7/1/61", bus.level, bus.overflow, bus.rd_data);
        end
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            got = (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hXX;
            n_checks++;
            if (bus.rd_data !== got || bus.rd_data === 8'hBB) begin
                n_fail++;
                $display("FAIL simul_full_drain[%0d]: data=%h want %h", i, bus.rd_data, got);
            end
        end
    endtask

    task automatic test_flush_reset();
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h81 + 8'(i), 1'b0);
        cyc(1'b1, 1'b1, 8'h99, 1'b0);
        n_checks++;
        if (bus.level !== 4'd0 || bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_mid: level=%0d empty=%b, want 0/1", bus.level, bus.empty);
        end
        cyc(1'b0, 1'b1, 8'h5A, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        got = (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hXX;
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h5A || got !== 8'h5A) begin
            n_fail++;
            $display("FAIL flush_then_pop: vld=%b data=%h, want 1/5a", bus.rd_valid, bus.rd_data);
        end
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h91 + 8'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.level !== 4'd0 || bus.empty !== 1'b1 || bus.rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid: level=%0d empty=%b data=%h, want 0/1/00", bus.level, bus.empty, bus.rd_data);
        end
        release_reset();
        cyc(1'b0, 1'b1, 8'h5A, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        got = (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hXX;
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h5A || got !== 8'h5A || bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_then_pop: vld=%b data=%h empty=%b, want 1/5a/1", bus.rd_valid, bus.rd_data, bus.empty);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.flush   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.rd_en   = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        release_reset();

        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_flush_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
